// File: rtl/sample_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_sched_pkg
// Description : Shared types and widths for the per-sample scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_sched_pkg;

    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADC_START = 3'd1,
        ADC_WAIT  = 3'd2,
        FILT      = 3'd3,
        MUX       = 3'd4,
        DAC_START = 3'd5,
        DAC_WAIT  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        MUTE     = 2'd0,
        BYPASS   = 2'd1,
        FILTERED = 2'd2
    } mode_t;

endpackage
`default_nettype wire

// File: rtl/period_counter.sv
`default_nettype none
// ============================================================================
// Module      : period_counter
// Description : Free-running 0..DIVIDER-1 counter; tick_o marks the last count.
// Revision    : 1.0 - initial release
// ============================================================================
module period_counter #(
    parameter int DIVIDER = 1250
) (
    input  logic clk_i,
    input  logic reset_ni,
    output logic tick_o
);

    localparam int                 c_cnt_w = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DIVIDER - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick_o = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sample_scheduler
// Description : ADC -> filter -> DAC sequencer with overrun/timeout sticky flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_scheduler
    import sample_sched_pkg::*;
#(
    parameter int DIVIDER  = 1250,
    parameter int FILT_LAT = 2,
    parameter int TIMEOUT  = 1000
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       enable_i,
    input  logic [1:0]                 mode_i,
    output logic                       adc_start_o,
    input  logic                       adc_idle_i,
    input  logic signed [SAMPLE_W-1:0] adc_data_i,
    output logic                       filt_stb_o,
    output logic signed [SAMPLE_W-1:0] filt_sample_o,
    input  logic signed [SAMPLE_W-1:0] filt_data_i,
    output logic                       dac_start_o,
    output logic signed [SAMPLE_W-1:0] dac_data_o,
    input  logic                       dac_idle_i,
    output logic                       overrun_o,
    output logic                       timeout_o,
    input  logic                       clr_i,
    output logic [15:0]                sample_cnt_o
);

    localparam int                  c_wait_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_wait_w-1:0] c_wait_one  = c_wait_w'(1);
    localparam int                  c_lat_w     = $clog2(FILT_LAT + 1);
    localparam logic [c_lat_w-1:0]  c_lat_last  = c_lat_w'(FILT_LAT - 1);
    localparam logic [c_lat_w-1:0]  c_lat_one   = c_lat_w'(1);
    localparam logic [15:0]         c_cnt_one   = 16'd1;

    logic                       w_tick;
    state_t                     r_state;
    logic [c_wait_w-1:0]        r_wait_cnt;
    logic [c_lat_w-1:0]         r_lat_cnt;
    logic                       r_seen_busy;
    logic                       r_adc_start;
    logic                       r_filt_stb;
    logic                       r_dac_start;
    logic signed [SAMPLE_W-1:0] r_filt_sample;
    logic signed [SAMPLE_W-1:0] r_dac_data;
    logic                       r_overrun;
    logic                       r_timeout;
    logic [15:0]                r_sample_cnt;

    period_counter #(
        .DIVIDER (DIVIDER)
    ) u_period_counter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .tick_o   (w_tick)
    );

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state       <= IDLE;
            r_wait_cnt    <= '0;
            r_lat_cnt     <= '0;
            r_seen_busy   <= 1'b0;
            r_adc_start   <= 1'b0;
            r_filt_stb    <= 1'b0;
            r_dac_start   <= 1'b0;
            r_filt_sample <= '0;
            r_dac_data    <= '0;
            r_overrun     <= 1'b0;
            r_timeout     <= 1'b0;
            r_sample_cnt  <= '0;
        end else begin
            r_adc_start <= 1'b0;
            r_filt_stb  <= 1'b0;
            r_dac_start <= 1'b0;

            // Clear is written first so any set below in the same cycle wins.
            if (clr_i) begin
                r_overrun <= 1'b0;
                r_timeout <= 1'b0;
            end
            if (w_tick && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_tick && enable_i) begin
                        r_adc_start <= 1'b1;
                        r_state     <= ADC_START;
                    end
                end
                ADC_START: begin
                    r_wait_cnt  <= '0;
                    r_seen_busy <= 1'b0;
                    r_state     <= ADC_WAIT;
                end
                ADC_WAIT: begin
                    if (r_seen_busy && adc_idle_i) begin
                        r_filt_sample <= adc_data_i;
                        r_filt_stb    <= 1'b1;
                        r_lat_cnt     <= '0;
                        r_state       <= FILT;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                        if (!adc_idle_i) begin
                            r_seen_busy <= 1'b1;
                        end
                    end
                end
                FILT: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= MUX;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_lat_one;
                    end
                end
                MUX: begin
                    case (mode_i)
                        MUTE:    r_dac_data <= '0;
                        BYPASS:  r_dac_data <= r_filt_sample;
                        default: r_dac_data <= filt_data_i;
                    endcase
                    r_state <= DAC_START;
                end
                DAC_START: begin
                    // Pulse lands in the first DAC_WAIT cycle, FILT_LAT+2 after filt_stb_o.
                    r_dac_start <= 1'b1;
                    r_wait_cnt  <= '0;
                    r_seen_busy <= 1'b0;
                    r_state     <= DAC_WAIT;
                end
                DAC_WAIT: begin
                    if (r_seen_busy && dac_idle_i) begin
                        r_sample_cnt <= r_sample_cnt + c_cnt_one;
                        r_state      <= IDLE;
                    end else if (r_wait_cnt == c_wait_last) begin
                        r_timeout <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_one;
                        if (!dac_idle_i) begin
                            r_seen_busy <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign adc_start_o   = r_adc_start;
    assign filt_stb_o    = r_filt_stb;
    assign filt_sample_o = r_filt_sample;
    assign dac_start_o   = r_dac_start;
    assign dac_data_o    = r_dac_data;
    assign overrun_o     = r_overrun;
    assign timeout_o     = r_timeout;
    assign sample_cnt_o  = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_scheduler
// Description : Directed self-checking bench for sample_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_scheduler;

    localparam int DIVIDER  = 64;
    localparam int FILT_LAT = 2;
    localparam int TIMEOUT  = 100;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable  = 1'b0;
    logic        clr     = 1'b0;
    logic [1:0]  mode    = 2'd2;
    logic        adc_start, filt_stb, dac_start, overrun, timeout;
    logic        adc_idle, dac_idle;
    logic [15:0] adc_data, filt_sample, filt_data, dac_data, sample_cnt;

    int cyc    = 0;
    int n_adc  = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_scheduler #(
        .DIVIDER  (DIVIDER),
        .FILT_LAT (FILT_LAT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .reset_ni      (reset_n),
        .enable_i      (enable),
        .mode_i        (mode),
        .adc_start_o   (adc_start),
        .adc_idle_i    (adc_idle),
        .adc_data_i    (adc_data),
        .filt_stb_o    (filt_stb),
        .filt_sample_o (filt_sample),
        .filt_data_i   (filt_data),
        .dac_start_o   (dac_start),
        .dac_data_o    (dac_data),
        .dac_idle_i    (dac_idle),
        .overrun_o     (overrun),
        .timeout_o     (timeout),
        .clr_i         (clr),
        .sample_cnt_o  (sample_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (adc_start) n_adc <= n_adc + 1;

    // ADC reader: busy for adc_busy_len cycles after a start, then presents adc_val.
    int          adc_busy_len = 20;
    logic [15:0] adc_val      = 16'h1234;
    int          adc_left     = 0;
    logic        adc_idle_r   = 1'b1;
    logic [15:0] adc_data_r   = 16'h0000;
    always @(posedge clk) begin
        if (adc_start) begin
            adc_idle_r <= 1'b0;
            adc_left   <= adc_busy_len - 1;
        end else if (!adc_idle_r) begin
            if (adc_left == 0) begin
                adc_idle_r <= 1'b1;
                adc_data_r <= adc_val;
            end else begin
                adc_left <= adc_left - 1;
            end
        end
    end
    assign adc_idle = adc_idle_r;
    assign adc_data = adc_data_r;

    // DAC writer: busy 5 cycles; dac_stuck pins idle low.
    logic dac_stuck  = 1'b0;
    int   dac_left   = 0;
    logic dac_idle_r = 1'b1;
    always @(posedge clk) begin
        if (dac_start) begin
            dac_idle_r <= 1'b0;
            dac_left   <= 4;
        end else if (!dac_idle_r) begin
            if (dac_left == 0) dac_idle_r <= 1'b1;
            else               dac_left   <= dac_left - 1;
        end
    end
    assign dac_idle = dac_idle_r & ~dac_stuck;

    // Filter: result valid only exactly FILT_LAT (=2) cycles after the strobe.
    logic p1 = 1'b0, p2 = 1'b0;
    always @(posedge clk) begin
        p1 <= filt_stb;
        p2 <= p1;
    end
    assign filt_data = p2 ? (filt_sample ^ 16'hFFFF) : 16'hDEAD;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel_sig(input int sel);
        case (sel)
            0:       return adc_start;
            1:       return filt_stb;
            default: return dac_start;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int budget, input string tag, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            step();
            if (sel_sig(sel)) begin
                at = cyc;
                break;
            end
        end
        checks++;
        assert (at >= 0) else begin
            errors++;
            $error("FAIL %s observed=no_pulse expected=pulse_within_%0d", tag, budget);
        end
    endtask

    task automatic run_sample(input string tag, output int a, output int d);
        wait_for(0, 200, {tag, "_adc_start"}, a);
        wait_for(2, 120, {tag, "_dac_start"}, d);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel, a, f, d, a2, d2, n0;
        enable  = 1'b1;
        mode    = 2'd2;
        reset_n = 1'b0;
        repeat (3) step();
        check("rst_strobes_flags", {adc_start, filt_stb, dac_start, overrun, timeout}, 0);
        check("rst_filt_sample", filt_sample, 0);
        check("rst_dac_data", dac_data, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;

        // Nominal filtered path
        wait_for(0, 100, "nom_adc_start", a);
        check("nom_start_latency", a - rel, DIVIDER);
        step();
        check("nom_adc_start_width", adc_start, 0);
        wait_for(1, 40, "nom_filt_stb", f);
        check("nom_filt_gap", f - a, 22);
        check("nom_filt_sample", filt_sample, 16'h1234);
        wait_for(2, 20, "nom_dac_start", d);
        check("nom_dac_gap", d - f, FILT_LAT + 2);
        check("nom_dac_data", dac_data, 16'hEDCB);
        step();
        check("nom_dac_start_width", dac_start, 0);
        repeat (10) step();
        check("nom_sample_cnt", sample_cnt, 1);
        run_sample("nom2", a2, d2);
        check("nom_period", a2 - a, DIVIDER);
        repeat (10) step();
        check("nom2_sample_cnt", sample_cnt, 2);
        check("nom_overrun", overrun, 0);

        // Output modes
        mode = 2'd0;
        run_sample("mute", a, d);
        check("mute_dac_data", dac_data, 16'h0000);
        repeat (10) step();
        mode = 2'd1;
        run_sample("bypass", a, d);
        check("bypass_dac_data", dac_data, 16'h1234);
        repeat (10) step();
        adc_val = 16'h8000;
        run_sample("bypass_neg", a, d);
        check("bypass_neg_sample", filt_sample, 16'h8000);
        check("bypass_neg_dac", dac_data, 16'h8000);
        repeat (10) step();
        check("modes_sample_cnt", sample_cnt, 5);

        // Overrun: ADC busy longer than a period
        adc_val      = 16'h1234;
        mode         = 2'd2;
        adc_busy_len = 70;
        run_sample("ovr", a, d);
        repeat (10) step();
        check("ovr_set", overrun, 1);
        check("ovr_sample_cnt", sample_cnt, 6);
        wait_for(0, 200, "ovr2_adc_start", a2);
        check("ovr_two_periods", a2 - a, 2 * DIVIDER);
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovr_clr", overrun, 0);
        while (cyc < a2 + DIVIDER - 1) step();
        check("ovr_before_tick", overrun, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovr_set_beats_clr", overrun, 1);
        adc_busy_len = 20;
        wait_for(2, 120, "ovr2_dac_start", d);
        repeat (10) step();
        check("ovr2_sample_cnt", sample_cnt, 7);
        run_sample("ovr3", a, d);
        repeat (10) step();
        check("ovr3_sample_cnt", sample_cnt, 8);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovr_final_clr", overrun, 0);

        // Timeout on a stuck DAC
        dac_stuck = 1'b1;
        run_sample("to", a, d);
        while (cyc < d + TIMEOUT - 1) step();
        check("to_before", timeout, 0);
        step();
        check("to_set", timeout, 1);
        check("to_cnt_hold", sample_cnt, 8);
        check("to_dac_hold", dac_data, 16'hEDCB);
        dac_stuck = 1'b0;
        run_sample("to_next", a2, d2);
        check("to_next_period", a2 - a, 2 * DIVIDER);
        repeat (10) step();
        check("to_next_cnt", sample_cnt, 9);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("to_clr", {timeout, overrun}, 0);

        // Asynchronous reset during ADC_WAIT
        wait_for(0, 100, "arst_adc_start", a);
        repeat (5) step();
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_filt_sample", filt_sample, 0);
        check("arst_dac_data", dac_data, 0);
        check("arst_sample_cnt", sample_cnt, 0);
        repeat (2) step();
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        n0  = n_adc;
        wait_for(0, 100, "arst_adc_start2", a);
        check("arst_no_early_start", n_adc - n0, 0);
        check("arst_start_latency", a - rel, DIVIDER);
        wait_for(2, 60, "arst_dac_start", d);
        repeat (10) step();
        check("arst_sample_cnt2", sample_cnt, 1);

        // Enable gating
        enable = 1'b0;
        n0 = n_adc;
        repeat (140) step();
        check("en_low_no_start", n_adc - n0, 0);
        enable = 1'b1;
        wait_for(0, 100, "en_adc_start", a);
        wait_for(1, 40, "en_filt_stb", f);
        step();
        enable = 1'b0;
        wait_for(2, 20, "en_drop_dac_start", d);
        check("en_drop_dac_data", dac_data, 16'hEDCB);
        repeat (10) step();
        check("en_drop_cnt", sample_cnt, 2);
        n0 = n_adc;
        repeat (70) step();
        check("en_drop_no_restart", n_adc - n0, 0);

        // Sample counter wrap
        enable = 1'b1;
        force dut.r_sample_cnt = 16'hFFFF;
        step();
        release dut.r_sample_cnt;
        step();
        check("wrap_preload", sample_cnt, 16'hFFFF);
        run_sample("wrap", a, d);
        repeat (10) step();
        check("wrap_cnt", sample_cnt, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_scheduler.md
# sample_scheduler

Per-sample sequencer for the audio-rate ADC → filter → DAC datapath. Generates the sample period internally and issues one ADC conversion per period. It presents the captured sample to the filter bank as a one-cycle strobe, collects the filter result after a fixed latency, applies the output mode mute/bypass/filter, then starts the DAC write. Overruns and stalled SPI engines are reported as sticky flags.

## Interface
Parameters:
- `DIVIDER`, 1250, sample period in clk cycles; minimum 16.
- `FILT_LAT`, 2, cycles from `filt_stb_o` to a valid `filt_data_i`; minimum 1.
- `TIMEOUT`, 1000, maximum cycles spent in either WAIT state before abort.

Ports:
- `clk_i`, in, 1, single system clock; all logic in this one domain.
- `reset_ni`, in, 1, reset; asynchronous, active-low.
- `enable_i`, in, 1, level; when low, no new sample is started.
- `mode_i`, in, 2, output mode: 0 mute, 1 bypass, 2/3 filtered.
- `adc_start_o`, out, 1, one-cycle start pulse to the ADC reader.
- `adc_idle_i`, in, 1, ADC reader idle status.
- `adc_data_i`, in, 16 signed, ADC sample; valid when `adc_idle_i` returns high.
- `filt_stb_o`, out, 1, one-cycle sample strobe to the filter.
- `filt_sample_o`, out, 16 signed, registered sample for the filter input.
- `filt_data_i`, in, 16 signed, filter output.
- `dac_start_o`, out, 1, one-cycle start pulse to the DAC writer.
- `dac_data_o`, out, 16 signed, registered DAC word; stable from `dac_start_o` until the next `dac_start_o`.
- `dac_idle_i`, in, 1, DAC writer idle status.
- `overrun_o`, out, 1, sticky: a period tick arrived while busy.
- `timeout_o`, out, 1, sticky: a WAIT state exceeded `TIMEOUT`.
- `clr_i`, in, 1, synchronous clear of both sticky flags.
- `sample_cnt_o`, out, 16, count of completed samples; wraps from 0xFFFF to 0.

## Operation
- **Period counter:** free-runs 0..`DIVIDER`-1. `tick` is asserted at count `DIVIDER`-1. The counter keeps running independent of `enable_i` and of the FSM state.

FSM states: IDLE, ADC_START, ADC_WAIT, FILT, MUX, DAC_START, DAC_WAIT.
- **IDLE:** on `tick` with `enable_i` high → ADC_START; otherwise stay.
- **ADC_START:** `adc_start_o`=1 for this cycle → ADC_WAIT. Clear the wait counter and the `seen_busy` flag.
- **ADC_WAIT:** set `seen_busy` when `adc_idle_i`=0. Once `seen_busy` is set and `adc_idle_i`=1: latch `adc_data_i` into `filt_sample_o`, pulse `filt_stb_o` → FILT.
- **FILT:** count `FILT_LAT` cycles → MUX.
- **MUX:** load `dac_data_o` per `mode_i`: 0 gives 0x0000, 1 gives `filt_sample_o`, 2/3 gives `filt_data_i` → DAC_START.
- **DAC_START:** `dac_start_o`=1 → DAC_WAIT, using the same `seen_busy` and wait-counter scheme.
- **DAC_WAIT:** once `seen_busy` is set and `dac_idle_i`=1: increment `sample_cnt_o` → IDLE.
- **Timeout:** if the wait counter reaches `TIMEOUT` in either WAIT state, set `timeout_o` and go → IDLE. `sample_cnt_o` is not incremented and `dac_data_o` keeps its last value.
- **Overrun:** a `tick` in any state other than IDLE sets `overrun_o`. That tick is dropped; it is neither queued nor allowed to restart the sequence.
- **Sticky flags:** `clr_i` clears both flags. If `clr_i` coincides with a set event, the set wins.
- **`enable_i` low mid-sequence:** the current sample completes normally.
- **Reset:** asserting `reset_ni` in any state immediately returns the FSM to IDLE.

## Timing
- **Reset values:** every output is 0 (strobes, data, flags, counter), FSM is IDLE, period counter is 0.
- **Start latency:** `adc_start_o` is asserted 1 cycle after the `tick` cycle.
- **Filter hand-off:** `filt_stb_o` is asserted in the cycle after `adc_idle_i` is first sampled high following the busy phase. `filt_sample_o` is valid in that same cycle.
- **DAC start:** `dac_start_o` is asserted `FILT_LAT`+2 cycles after `filt_stb_o`.
- **Strobes:** all strobes are exactly one cycle wide and registered; no combinational path from inputs to outputs.
- **Throughput:** one sample per `DIVIDER` cycles, provided ADC and DAC busy time plus `FILT_LAT`+6 is less than `DIVIDER`.

## Structure
- **Package `sample_sched_pkg`:** `state_t` enum (7 states), `mode_t` enum (MUTE, BYPASS, FILTERED), `SAMPLE_W` = 16.
- **Sub-module `period_counter`:** parameter `DIVIDER`; ports `clk_i`, `reset_ni`, `tick_o`.
- **Top module:** the FSM, wait counter, `seen_busy`, output mux, and flags stay in `sample_scheduler`.

## Test plan
1. **Nominal:** `DIVIDER`=64, `FILT_LAT`=2, mode 2. ADC model busy 20 cycles, returning 0x1234; filter model returns sample XOR 0xFFFF → `dac_data_o`=0xEDCB, `dac_start_o` at the expected cycle, `sample_cnt_o`=1 per period, `overrun_o`=0.
2. **Modes:** same stimulus with mode 0 → 0x0000; mode 1 → 0x1234. Test -32768 in bypass → 0x8000, sign preserved.
3. **Overrun:** ADC busy 70 cycles with `DIVIDER`=64 → `overrun_o`=1, exactly one sample per two periods. `clr_i` pulse clears the flag; `clr_i` coincident with a tick while busy → flag stays 1.
4. **Timeout:** `dac_idle_i` held low, `TIMEOUT`=100 → `timeout_o`=1 after 100 wait cycles, FSM returns to IDLE, `sample_cnt_o` unchanged, next period proceeds normally.
5. **Reset / enable:** assert `reset_ni` low during ADC_WAIT → all outputs 0 asynchronously, no start pulse after release until the first tick. `enable_i` low → no `adc_start_o`; dropping `enable_i` in FILT still completes the DAC write.
6. **Wrap:** preload `sample_cnt_o` to 0xFFFF via force, then run one sample → 0x0000.
